// File: rtl/puf_pkg.sv
// Types and sizes shared by the challenge deframer, the PUF controller and the arbiter PUF.
package puf_pkg;

   localparam int CHAL_BYTES = 8;
   localparam int CHAL_W     = 8 * CHAL_BYTES;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } deframer_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector. The reset value of the history bit sets whether
// a level that is already high when reset is released counts as an edge.
module rise_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic prev_r;

   // history of d, one cycle behind
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_r <= RESET_VAL;
      end else begin
         prev_r <= d;
      end
   end

   assign rise = d & ~prev_r;

endmodule

// File: rtl/challenge_deframer.sv
// Packs NBYTES uart_rx bytes (MSB first) into one PUF challenge word, drops partial frames
// that stall past TIMEOUT_CYCLES, and hands finished words downstream via valid/ready.
module challenge_deframer
   import puf_pkg::*;
#(
   parameter int NBYTES         = CHAL_BYTES,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   output logic [8*NBYTES-1:0]   challenge,
   output logic                  challenge_valid,
   input  logic                  challenge_ready,
   output logic                  busy,
   output logic                  timeout_err,
   output logic                  overrun_err
);

   localparam int W  = 8 * NBYTES;
   localparam int CW = $clog2(NBYTES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   deframer_state_t state_r, state_nxt_s, start_state_s;
   logic [CW-1:0]   count_r, count_nxt_s;
   logic [TW-1:0]   tmo_r, tmo_nxt_s;
   logic            strobe_s;
   logic            shift_s;
   logic            tmo_pulse_s;
   logic            ovr_pulse_s;

   rise_detect #(
      .RESET_VAL (1'b1)
   ) u_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_valid),
      .rise  (strobe_s)
   );

   // a single-byte frame is complete on its first byte
   assign start_state_s = (LAST_CNT == CW'(1)) ? HOLD : COLLECT;

   // next-state, counter and pulse decode
   always_comb begin
      state_nxt_s = state_r;
      count_nxt_s = count_r;
      tmo_nxt_s   = tmo_r;
      shift_s     = 1'b0;
      tmo_pulse_s = 1'b0;
      ovr_pulse_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (strobe_s) begin
               shift_s     = 1'b1;
               count_nxt_s = CW'(1);
               tmo_nxt_s   = '0;
               state_nxt_s = start_state_s;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         COLLECT: begin
            if (strobe_s) begin
               shift_s     = 1'b1;
               count_nxt_s = count_r + CW'(1);
               tmo_nxt_s   = '0;
               if (count_r == LAST_CNT - CW'(1)) begin
                  state_nxt_s = HOLD;
               end else begin
                  state_nxt_s = COLLECT;
               end
            end else if (tmo_r == TMO_LAST) begin
               tmo_pulse_s = 1'b1;
               count_nxt_s = '0;
               tmo_nxt_s   = '0;
               state_nxt_s = IDLE;
            end else begin
               tmo_nxt_s   = tmo_r + TW'(1);
            end
         end
         HOLD: begin
            if (challenge_ready) begin
               // a byte arriving on the handshake cycle opens the next frame
               if (strobe_s) begin
                  shift_s     = 1'b1;
                  count_nxt_s = CW'(1);
                  tmo_nxt_s   = '0;
                  state_nxt_s = start_state_s;
               end else begin
                  count_nxt_s = '0;
                  state_nxt_s = IDLE;
               end
            end else if (strobe_s) begin
               ovr_pulse_s = 1'b1;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            count_nxt_s = '0;
            tmo_nxt_s   = '0;
         end
      endcase
   end

   // state, counters, shift register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= IDLE;
         count_r         <= '0;
         tmo_r           <= '0;
         challenge       <= '0;
         challenge_valid <= 1'b0;
         busy            <= 1'b0;
         timeout_err     <= 1'b0;
         overrun_err     <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         count_r         <= count_nxt_s;
         tmo_r           <= tmo_nxt_s;
         if (shift_s) begin
            challenge    <= W'({challenge, rx_byte});
         end
         challenge_valid <= (state_nxt_s == HOLD);
         busy            <= (state_nxt_s == COLLECT);
         timeout_err     <= tmo_pulse_s;
         overrun_err     <= ovr_pulse_s;
      end
   end

endmodule

// File: tb/tb_challenge_deframer.sv
// Bench for challenge_deframer: directed scenarios plus random traffic, checked by a
// byte-queue reference model feeding a scoreboard of expected challenge words.
module tb_challenge_deframer;

   localparam int NB  = 8;
   localparam int TMO = 100;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            rx_valid = 1'b0;
   logic [7:0]      rx_byte = 8'h00;
   logic            challenge_ready = 1'b0;
   logic [8*NB-1:0] challenge;
   logic            challenge_valid;
   logic            busy;
   logic            timeout_err;
   logic            overrun_err;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [7:0]      m_bytes[$];
   logic [8*NB-1:0] exp_q[$];
   int              m_idle = 0;
   bit              m_prev = 1'b1;
   bit              m_hold = 1'b0;
   bit              m_busy = 1'b0;
   bit              m_valid = 1'b0;
   bit              m_tmo = 1'b0;
   bit              m_ovr = 1'b0;

   challenge_deframer #(
      .NBYTES         (NB),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx_valid        (rx_valid),
      .rx_byte         (rx_byte),
      .challenge       (challenge),
      .challenge_valid (challenge_valid),
      .challenge_ready (challenge_ready),
      .busy            (busy),
      .timeout_err     (timeout_err),
      .overrun_err     (overrun_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int hi, input int gap);
      rx_byte  = b;
      rx_valid = 1'b1;
      cyc(hi);
      rx_valid = 1'b0;
      cyc(gap);
   endtask

   task automatic send_frame(input logic [7:0] first);
      for (int i = 0; i < NB; i++) begin
         send_byte(first + 8'(i), 3, 20);
      end
   endtask

   // Reference model: one byte per rising edge of rx_valid, bytes queued until a frame
   // is complete, a frame waits for ready, and a stall of TMO idle cycles discards it.
   initial begin
      logic            strobe;
      logic [8*NB-1:0] word;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_prev = 1'b1;
            m_bytes.delete();
            exp_q.delete();
            m_idle = 0;
            m_hold = 1'b0;
            m_tmo  = 1'b0;
            m_ovr  = 1'b0;
         end else begin
            strobe = rx_valid && !m_prev;
            m_prev = rx_valid;
            m_tmo  = 1'b0;
            m_ovr  = 1'b0;
            if (m_hold) begin
               if (challenge_ready) begin
                  m_hold = 1'b0;
                  if (strobe) begin
                     m_bytes.push_back(rx_byte);
                     m_idle = 0;
                  end
               end else if (strobe) begin
                  m_ovr = 1'b1;
               end
            end else if (strobe) begin
               m_bytes.push_back(rx_byte);
               m_idle = 0;
               if (m_bytes.size() == NB) begin
                  word = '0;
                  foreach (m_bytes[i]) word = (word << 8) | (8*NB)'(m_bytes[i]);
                  exp_q.push_back(word);
                  m_bytes.delete();
                  m_hold = 1'b1;
               end
            end else if (m_bytes.size() != 0) begin
               m_idle++;
               if (m_idle == TMO) begin
                  m_tmo = 1'b1;
                  m_bytes.delete();
                  m_idle = 0;
               end
            end
         end
         m_busy  = (m_bytes.size() != 0);
         m_valid = m_hold;
      end
   end

   // Monitor: compare flags every cycle; compare the presented word against the scoreboard
   // head whenever valid is high, and retire it on the handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("challenge_valid", 64'(challenge_valid), 64'(m_valid));
            chk("timeout_err", 64'(timeout_err), 64'(m_tmo));
            chk("overrun_err", 64'(overrun_err), 64'(m_ovr));
            if (challenge_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL challenge_unexpected actual=%h expected=none at %0t", challenge, $time);
               end else begin
                  chk("challenge", challenge, exp_q[0]);
                  if (challenge_ready) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int gap;
      cyc(2);
      chk("rst_challenge", challenge, 64'h0);
      chk("rst_valid", 64'(challenge_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_errs", 64'({timeout_err, overrun_err}), 64'h0);
      rst_n = 1'b1;
      cyc(2);

      // frame assembly with ready held high
      challenge_ready = 1'b1;
      send_frame(8'h01);

      // frame held while ready is low
      challenge_ready = 1'b0;
      send_frame(8'h01);
      cyc(30);
      chk("hold_value", challenge, 64'h0102030405060708);
      chk("hold_valid", 64'(challenge_valid), 64'h1);
      challenge_ready = 1'b1;
      cyc(3);

      // partial frame timeout, then a clean frame
      send_byte(8'hAA, 3, 20);
      send_byte(8'hBB, 3, 20);
      send_byte(8'hCC, 3, 110);
      chk("tmo_busy", 64'(busy), 64'h0);
      send_frame(8'h11);

      // overrun while holding, then strobe coinciding with ready
      challenge_ready = 1'b0;
      send_frame(8'h21);
      send_byte(8'h55, 3, 5);
      chk("ovr_value", challenge, 64'h2122232425262728);
      rx_byte = 8'h66;
      rx_valid = 1'b1;
      challenge_ready = 1'b1;
      cyc(1);
      challenge_ready = 1'b0;
      cyc(2);
      rx_valid = 1'b0;
      cyc(3);
      chk("restart_busy", 64'(busy), 64'h1);
      for (int i = 1; i < NB; i++) send_byte(8'h66 + 8'(i), 2, 10);
      challenge_ready = 1'b1;
      cyc(3);

      // rx_valid held high counts as one byte
      send_byte(8'h7E, 40, 5);
      chk("held_busy", 64'(busy), 64'h1);
      for (int i = 1; i < NB; i++) send_byte(8'h70 + 8'(i), 1, 8);
      cyc(3);

      // reset released while rx_valid high gives no strobe
      rx_byte = 8'h99;
      rx_valid = 1'b1;
      rst_n = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(5);
      chk("rst_held_busy", 64'(busy), 64'h0);
      rx_valid = 1'b0;
      cyc(3);

      // async reset mid-frame
      for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 2, 6);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_busy", 64'(busy), 64'h0);
      chk("async_challenge", challenge, 64'h0);
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      send_frame(8'hC1);
      chk("post_rst_value", challenge, 64'hC1C2C3C4C5C6C7C8);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         challenge_ready = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 14))
            0:       gap = $urandom_range(96, 104);
            1:       gap = 0;
            default: gap = $urandom_range(1, 30);
         endcase
         send_byte(8'($urandom), $urandom_range(1, 4), gap);
      end
      challenge_ready = 1'b1;
      cyc(5);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/challenge_deframer.md
Name: challenge_deframer

Overview:
- Sits directly upstream of the PUF controller path, between uart_rx and the challenge register of the arbiter PUF.
- Edge-detects uart_rx byte strobes and assembles NBYTES bytes, MSB-first, into one challenge word.
- Enforces an inter-byte timeout so a partial frame cannot corrupt the next challenge.
- Presents the completed challenge to the downstream controller over a valid/ready handshake.

Parameters:
- NBYTES, 8: bytes per challenge frame; challenge width = 8*NBYTES.
- TIMEOUT_CYCLES, 1000000: idle clock cycles allowed between bytes of one frame before the partial frame is discarded.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_valid  input  1  uart_rx byte-done flag; may stay high multiple cycles.
- rx_byte  input  8  uart_rx received byte; stable while rx_valid high.
- challenge  output  8*NBYTES  assembled challenge; first received byte in bits [8*NBYTES-1 -: 8].
- challenge_valid  output  1  challenge holds a complete frame.
- challenge_ready  input  1  downstream accepts the frame when high with challenge_valid.
- busy  output  1  high in COLLECT (partial frame held).
- timeout_err  output  1  one-cycle pulse when a partial frame is discarded on timeout.
- overrun_err  output  1  one-cycle pulse when a byte is dropped in HOLD.

Behaviour:
- Reset (async, rst_n=0): state IDLE, challenge=0, challenge_valid=0, busy=0, timeout_err=0, overrun_err=0, byte count=0, timeout count=0, prev_rx_valid=1. prev resets to 1 so a rx_valid already high across reset release produces no strobe.
- strobe = rx_valid & ~prev_rx_valid. prev_rx_valid registers rx_valid every cycle. Exactly one byte per rising edge of rx_valid.
- Shift rule on a strobe: challenge <= {challenge[8*NBYTES-9:0], rx_byte}. Byte count width $clog2(NBYTES+1).
- IDLE: on strobe, shift in the byte, count=1, timeout count=0, go to COLLECT.
- COLLECT:
  - On strobe: shift, count+1, timeout count=0.
  - If that strobe makes count==NBYTES: go to HOLD, with challenge_valid=1 on the following cycle. Latency is 1 clock after the final strobe edge.
  - No strobe: timeout count+1. On reaching TIMEOUT_CYCLES-1: pulse timeout_err, clear count, go to IDLE. challenge is not cleared, but it is never presented, since valid is only set via HOLD.
- HOLD:
  - challenge_valid=1 and challenge stable until challenge_ready=1 (handshake cycle), then challenge_valid=0 next cycle.
  - Strobe without ready: byte dropped, overrun_err pulsed, challenge unchanged.
  - Strobe and ready in the same cycle: handshake completes and the byte starts a new frame (count=1, COLLECT). No overrun_err.
- busy = (state==COLLECT). The timeout counter does not run in IDLE or HOLD.
- Reset mid-frame or mid-HOLD: everything returns to reset values immediately; the partial or pending frame is lost.
- Counters saturate by construction; no wrap beyond NBYTES or TIMEOUT_CYCLES.

Decomposition:
- Shared package puf_pkg:
  - CHAL_BYTES=8 and CHAL_W=64, also used by the controller and the arbiter PUF.
  - State enum typedef deframer_state_t {IDLE, COLLECT, HOLD}.
- One sub-module, rise_detect: registered edge detector with parameterised reset value. The remainder is flat.

Test Plan:
- Frame assembly: reset, then bytes 01,02,...,08 each as a 3-cycle rx_valid pulse 20 cycles apart, ready=1 → challenge_valid=1 one cycle after 8th edge with challenge=0x0102030405060708, for exactly 1 cycle. No error pulses.
- Hold until accepted: same frame with ready=0 for 50 cycles, then ready=1 → valid and value held all 50 cycles, drop the cycle after the handshake.
- Timeout (TIMEOUT_CYCLES=100): send AA,BB,CC then idle 100 cycles → timeout_err single pulse, busy falls. Then send 11..18 → challenge=0x1112131415161718, with no AA/BB/CC residue.
- Overrun: complete frame, ready=0, send byte 0x55 → overrun_err pulse, challenge unchanged. Then strobe 0x66 together with ready=1 → handshake, busy=1, count=1, no overrun_err.
- Held rx_valid: rx_valid high for 40 cycles with byte 0x7E → counted once (busy=1, one byte).
- Reset edge cases:
  - Reset asserted during rx_valid high, released while still high → no strobe.
  - Async reset after 5 bytes → busy=0 immediately, challenge=0, next 8 bytes form a clean frame.
